// File: rtl/axi_ctrl_pkg.sv
// Shared definitions for the AXI write burst controller.
// Contents:
//   wctrl_state_t   - controller state encoding, also exported as state_out
//   AXI_BURST_INCR  - AWBURST encoding for incrementing bursts
//   RESP_*          - BRESP encodings
package axi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RESP    = 3'd4
    } wctrl_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_write_burst_ctrl_if.sv
// AXI write address and write response channels as seen by the burst
// controller.
// Signals:
//   AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  master -> slave
//   AWREADY                                   slave  -> master
//   BID/BRESP/BVALID                          slave  -> master
//   BREADY                                    master -> slave
interface axi_write_burst_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [3:0]            AWID;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [3:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic [1:0]            AWBURST;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [3:0]            BID;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_write_burst_ctrl.sv
// Sequences one AXI write burst at a time: accepts a command, issues AW,
// runs the write-data-channel engine via dch_go/dch_done, collects B.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   axi (master)                AW and B channels
//   cmd_valid/ready/addr/len/id burst command
//   dch_go, dch_done,
//   dch_data_sent,
//   dch_last_transfer,
//   dch_transaction_id          data-channel engine handshake
//   resp_valid/code/id_err      burst completion report
//   busy, state_out             status / debug
//
// state   | meaning
// IDLE    | ready for a command
// ADDR    | AWVALID high, waiting for AWREADY
// DATA    | engine running, beats counted
// RELEASE | dch_go low one cycle so the engine returns to idle
// RESP    | BREADY high, waiting for BVALID
module axi_write_burst_ctrl
    import axi_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    axi_write_burst_ctrl_if.master axi,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [3:0]             cmd_len,
    input  logic [3:0]             cmd_id,
    output logic                   dch_go,
    input  logic                   dch_done,
    input  logic                   dch_data_sent,
    output logic                   dch_last_transfer,
    output logic [3:0]             dch_transaction_id,
    output logic                   resp_valid,
    output logic [1:0]             resp_code,
    output logic                   resp_id_err,
    output logic                   busy,
    output logic [2:0]             state_out
);

    localparam logic [2:0] AW_SIZE = 3'($clog2(DATA_WIDTH / 8));

    wctrl_state_t          state;
    wctrl_state_t          state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            len_q;
    logic [3:0]            id_q;
    logic [3:0]            beat_cnt;
    logic                  aw_valid_q;
    logic                  b_ready_q;
    logic                  cmd_accept;

    assign cmd_accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (cmd_accept) state_next = ST_ADDR;
            ST_ADDR:    if (axi.AWREADY) state_next = ST_DATA;
            ST_DATA:    if (dch_done) state_next = ST_RELEASE;
            ST_RELEASE: state_next = ST_RESP;
            ST_RESP:    if (axi.BVALID && b_ready_q) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they are flops
    // that line up exactly with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_ready   <= 1'b0;
            aw_valid_q  <= 1'b0;
            dch_go      <= 1'b0;
            b_ready_q   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_code   <= RESP_OKAY;
            resp_id_err <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            id_q        <= '0;
            beat_cnt    <= '0;
        end else begin
            cmd_ready  <= (state_next == ST_IDLE);
            aw_valid_q <= (state_next == ST_ADDR);
            dch_go     <= (state_next == ST_DATA);
            b_ready_q  <= (state_next == ST_RESP);
            resp_valid <= 1'b0;

            if (state == ST_IDLE && cmd_accept) begin
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                id_q     <= cmd_id;
                beat_cnt <= '0;
            end

            // Saturate at len so stray beat pulses cannot wrap the count.
            if (state == ST_DATA && dch_data_sent && beat_cnt != len_q) begin
                beat_cnt <= beat_cnt + 4'd1;
            end

            if (state == ST_RESP && axi.BVALID && b_ready_q) begin
                resp_valid  <= 1'b1;
                resp_code   <= axi.BRESP;
                resp_id_err <= (axi.BID != id_q);
            end
        end
    end

    assign axi.AWID    = id_q;
    assign axi.AWADDR  = addr_q;
    assign axi.AWLEN   = len_q;
    assign axi.AWSIZE  = AW_SIZE;
    assign axi.AWBURST = AXI_BURST_INCR;
    assign axi.AWVALID = aw_valid_q;
    assign axi.BREADY  = b_ready_q;

    assign dch_last_transfer  = (state == ST_DATA) && (beat_cnt == len_q);
    assign dch_transaction_id = id_q;
    assign busy               = (state != ST_IDLE);
    assign state_out          = state;

endmodule

// File: tb/tb_axi_write_burst_ctrl.sv
module tb_axi_write_burst_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic        dch_go;
    logic        dch_done;
    logic        dch_data_sent;
    logic        dch_last_transfer;
    logic [3:0]  dch_transaction_id;
    logic        resp_valid;
    logic [1:0]  resp_code;
    logic        resp_id_err;
    logic        busy;
    logic [2:0]  state_out;

    axi_write_burst_ctrl_if #(.ADDR_WIDTH(32)) axi ();

    axi_write_burst_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .axi                (axi),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_addr           (cmd_addr),
        .cmd_len            (cmd_len),
        .cmd_id             (cmd_id),
        .dch_go             (dch_go),
        .dch_done           (dch_done),
        .dch_data_sent      (dch_data_sent),
        .dch_last_transfer  (dch_last_transfer),
        .dch_transaction_id (dch_transaction_id),
        .resp_valid         (resp_valid),
        .resp_code          (resp_code),
        .resp_id_err        (resp_id_err),
        .busy               (busy),
        .state_out          (state_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] code;
        logic       id_err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   resp_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every resp_valid pulse pops the oldest expected response.
    always @(negedge clk) begin
        if (!reset && resp_valid === 1'b1) begin
            resp_seen++;
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_code", resp_code, e.code);
                chk("resp_id_err", resp_id_err, e.id_err);
            end
        end
    end

    task automatic run_burst(input logic [31:0] addr, input logic [3:0] len,
                             input logic [3:0] id, input logic [3:0] bid,
                             input logic [1:0] bresp, input int aw_wait,
                             input bit gap, input bit early_b, input int extra,
                             input int abort_at);
        int exp_cnt;
        int w;
        if (abort_at < 0) begin
            exp_q.push_back('{code: bresp, id_err: (bid != id)});
        end
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_id    = id;
        for (w = 0; w < 20 && cmd_ready !== 1'b1; w++) @(negedge clk);
        if (cmd_ready !== 1'b1) chk("cmd_ready_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = 32'hDEAD_BEEF;
        cmd_id    = 4'hF;
        chk("addr_state", state_out, 3'd1);
        chk("awlen", axi.AWLEN, len);
        chk("awsize", axi.AWSIZE, 3'd2);
        chk("awburst", axi.AWBURST, 2'b01);
        chk("addr_busy", busy, 1);
        for (int i = 0; i < aw_wait; i++) begin
            chk("awvalid_hold", axi.AWVALID, 1);
            chk("awaddr_stable", axi.AWADDR, addr);
            chk("awid_stable", axi.AWID, id);
            chk("go_before_aw", dch_go, 0);
            @(negedge clk);
        end
        chk("awvalid", axi.AWVALID, 1);
        chk("awaddr", axi.AWADDR, addr);
        chk("awid", axi.AWID, id);
        axi.AWREADY = 1'b1;
        @(negedge clk);
        axi.AWREADY = 1'b0;
        chk("data_state", state_out, 3'd2);
        chk("awvalid_drop", axi.AWVALID, 0);
        chk("dch_txn_id", dch_transaction_id, id);
        if (early_b) begin
            axi.BVALID = 1'b1;
            axi.BID    = bid;
            axi.BRESP  = bresp;
        end
        exp_cnt = 0;
        for (int p = 0; p < int'(len) + 1 + extra; p++) begin
            if (p == abort_at) begin
                dch_data_sent = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                chk("rst_state", state_out, 3'd0);
                chk("rst_go", dch_go, 0);
                chk("rst_awvalid", axi.AWVALID, 0);
                chk("rst_bready", axi.BREADY, 0);
                chk("rst_cmd_ready", cmd_ready, 0);
                chk("rst_resp_valid", resp_valid, 0);
                reset = 1'b0;
                @(negedge clk);
                chk("rst_release_ready", cmd_ready, 1);
                for (int k = 0; k < 4; k++) begin
                    chk("rst_no_resp", resp_valid, 0);
                    @(negedge clk);
                end
                return;
            end
            if (gap) begin
                dch_data_sent = 1'b0;
                @(negedge clk);
            end
            chk("last", dch_last_transfer, (exp_cnt == int'(len)));
            chk("data_go", dch_go, 1);
            chk("data_bready", axi.BREADY, 0);
            dch_data_sent = 1'b1;
            @(negedge clk);
            if (exp_cnt != int'(len)) exp_cnt++;
        end
        dch_data_sent = 1'b0;
        chk("last_end", dch_last_transfer, 1);
        @(negedge clk);
        chk("go_before_done", dch_go, 1);
        dch_done = 1'b1;
        @(negedge clk);
        dch_done = 1'b0;
        chk("release_state", state_out, 3'd3);
        chk("release_go", dch_go, 0);
        chk("release_last", dch_last_transfer, 0);
        chk("release_bready", axi.BREADY, 0);
        chk("release_txn_id", dch_transaction_id, id);
        @(negedge clk);
        chk("resp_state", state_out, 3'd4);
        chk("resp_bready", axi.BREADY, 1);
        chk("resp_pre_valid", resp_valid, 0);
        axi.BVALID = 1'b1;
        axi.BID    = bid;
        axi.BRESP  = bresp;
        @(negedge clk);
        axi.BVALID = 1'b0;
        axi.BID    = 4'h0;
        axi.BRESP  = 2'b00;
        chk("resp_valid_pulse", resp_valid, 1);
        chk("idle_after_resp", state_out, 3'd0);
        chk("idle_busy", busy, 0);
        chk("idle_bready", axi.BREADY, 0);
        @(negedge clk);
        chk("resp_valid_end", resp_valid, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        chk("global_timeout", 0, 1);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_addr      = '0;
        cmd_len       = '0;
        cmd_id        = '0;
        dch_done      = 1'b0;
        dch_data_sent = 1'b0;
        axi.AWREADY   = 1'b0;
        axi.BID       = '0;
        axi.BRESP     = '0;
        axi.BVALID    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", state_out, 3'd0);
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_awvalid", axi.AWVALID, 0);
        chk("reset_go", dch_go, 0);
        chk("reset_bready", axi.BREADY, 0);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_resp_code", resp_code, 0);
        chk("reset_busy", busy, 0);
        chk("reset_last", dch_last_transfer, 0);
        chk("reset_txn_id", dch_transaction_id, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", cmd_ready, 1);

        // single beat
        run_burst(32'h100, 4'd0, 4'd5, 4'd5, 2'b00, 0, 1'b0, 1'b0, 0, -1);
        // 16 beats, beat pulses every other cycle
        run_burst(32'h2000, 4'd15, 4'd1, 4'd1, 2'b00, 0, 1'b1, 1'b0, 0, -1);
        // AW back-pressure
        run_burst(32'hABC0, 4'd3, 4'd9, 4'd9, 2'b00, 7, 1'b0, 1'b0, 0, -1);
        // early B during DATA, SLVERR
        run_burst(32'h3000, 4'd2, 4'd6, 4'd6, 2'b10, 0, 1'b0, 1'b1, 0, -1);
        // ID mismatch, with stray beat pulses past the end
        run_burst(32'h4000, 4'd2, 4'd3, 4'd4, 2'b00, 0, 1'b0, 1'b0, 2, -1);
        // reset at beat 3 of 8
        run_burst(32'h5000, 4'd7, 4'd2, 4'd2, 2'b00, 1, 1'b0, 1'b0, 0, 3);
        // normal command after the aborted one
        run_burst(32'h6000, 4'd1, 4'hA, 4'hA, 2'b01, 2, 1'b1, 1'b0, 0, -1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("resp_count", resp_seen, 6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_write_burst_ctrl.md
# axi_write_burst_ctrl

Sequences one AXI write burst at a time: accepts a write command, issues it on the AW channel, drives the write-data-channel engine through its go/done handshake, and collects the B response. Sits between the command source (DMA or register front end) and the write-data-channel engine. It owns AWID/WID consistency and WLAST generation; the engine owns WDATA/WSTRB/WVALID.

## Interface
- `ADDR_WIDTH`, default 32: AWADDR and command address width.
- `DATA_WIDTH`, default 32: data bus width; sets AWSIZE = log2(DATA_WIDTH/8).
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake.
- `cmd_addr`  in  ADDR_WIDTH  burst start address.
- `cmd_len`  in  4  beats minus one (0..15).
- `cmd_id`  in  4  transaction ID.
- `AWID`  out  4; `AWADDR`  out  ADDR_WIDTH; `AWLEN`  out  4.
- `AWSIZE`  out  3; `AWBURST`  out  2, constant 2'b01 INCR.
- `AWVALID`  out  1; `AWREADY`  in  1.
- `BID`  in  4; `BRESP`  in  2; `BVALID`  in  1; `BREADY`  out  1.
- `dch_go`  out  1  start/hold the data-channel engine.
- `dch_done`  in  1  engine reports burst complete.
- `dch_data_sent`  in  1  one beat accepted this cycle.
- `dch_last_transfer`  out  1  current beat is last.
- `dch_transaction_id`  out  4  ID for the engine's WID capture.
- `resp_valid`  out  1  one-cycle pulse, burst finished.
- `resp_code`  out  2  latched BRESP.
- `resp_id_err`  out  1  BID ≠ issued ID; valid with `resp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `state_out`  out  3  state encoding, for debug.

## Operation
- States: IDLE=0, ADDR=1, DATA=2, RELEASE=3, RESP=4.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid` → latch addr/len/id, clear beat counter, go to ADDR.
- ADDR:
  - `AWVALID`=1 with latched fields.
  - On `AWREADY` → DATA.
  - AW fields are stable while AWVALID is high.
- DATA:
  - `dch_go`=1.
  - Beat counter (4 bit) increments on each `dch_data_sent`.
  - `dch_last_transfer` = (counter == latched len), combinational.
  - On `dch_done` → RELEASE.
- RELEASE:
  - `dch_go`=0 for one cycle so the engine returns to idle, then → RESP.
- RESP:
  - `BREADY`=1.
  - On `BVALID` → latch BRESP, compute id_err, pulse `resp_valid` next cycle, → IDLE.
- `dch_transaction_id` = latched id, held from ADDR through RELEASE.
- `BREADY` is 0 outside RESP; an early B response is back-pressured.
- `cmd_len`=0: `dch_last_transfer` is high from the first DATA cycle.
- Counter saturates at len; extra `dch_data_sent` pulses are ignored.
- Unused/illegal state encoding → IDLE.

## Timing
- Reset values: state IDLE, `cmd_ready`=0 during reset then 1.
- All other outputs 0 at reset, including `resp_code`=0 and counters.
- Reset mid-burst:
  - Returns to IDLE next edge.
  - `dch_go`, `AWVALID`, `BREADY` drop immediately, registered.
  - No `resp_valid` is issued.
- Command accept → AWVALID: 1 cycle.
- AW handshake → `dch_go`: 1 cycle.
- `dch_done` → `dch_go` low: 1 cycle.
- B handshake → `resp_valid`: 1 cycle.
- Minimum command-to-command spacing: 5 + beats + engine latency cycles.
- `AWVALID`, `dch_go`, `BREADY` and `resp_valid` are registered outputs.
- `dch_last_transfer` is combinational from state and counter.

## Structure
- Shared package `axi_ctrl_pkg`:
  - state enum `wctrl_state_t` (3 bit);
  - `AXI_BURST_INCR`;
  - BRESP constants OKAY/EXOKAY/SLVERR/DECERR.
- Single module, no sub-modules. The data-channel engine is instantiated alongside it at the next level up, not inside.

## Test plan
- Single beat:
  - Stimulus: cmd len=0, id=5, addr=0x100, AWREADY immediate.
  - Response: AWLEN=0; `dch_last_transfer` high on first DATA cycle.
  - BID=5 BRESP=00 → `resp_valid` pulse, resp_code=00, id_err=0.
- 16-beat burst:
  - Stimulus: len=15; `dch_data_sent` gated every other cycle.
  - Response: `dch_last_transfer` asserts only after 15 sent pulses; `dch_go` drops 1 cycle after `dch_done`.
- AW back-pressure:
  - Stimulus: AWREADY held low 7 cycles.
  - Response: AWVALID stays high with stable AWADDR/AWID; `dch_go` stays 0 until handshake.
- Early B:
  - Stimulus: BVALID asserted during DATA.
  - Response: BREADY=0 until RESP; accepted then; BRESP=10 → resp_code=10.
- ID mismatch:
  - Stimulus: issue id=3, return BID=4.
  - Response: `resp_id_err`=1 with `resp_valid`.
- Reset mid-DATA:
  - Stimulus: assert reset at beat 3 of 8.
  - Response: next cycle state IDLE, `dch_go`=0, no `resp_valid`.
  - A new command then completes normally.
